// File: rtl/rainbow_pwm.sv
// rainbow_pwm: RGB colour-wheel driver for a three-channel LED.
// Sweeps a 6-segment hue wheel at a programmable rate and renders each
// channel with per-channel PWM. The modes are rainbow, hold, static colour
// and off, and a global brightness scale applies to every channel.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   mode       0 rainbow, 1 hold, 2 static, 3 off
//   color_in   static colour {R,G,B}, R in the MSBs (mode 2)
//   brightness global scale, all-ones = unity
//   led        registered pin levels {R,G,B}
//   hue_wrap   one-cycle pulse after the hue wraps seg5/MAX -> seg0/0
module rainbow_pwm #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 12000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [3*PWM_BITS-1:0] color_in,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [2:0]            led,
    output logic                  hue_wrap
);

    localparam int unsigned         PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam int unsigned         PROD_W   = 2 * PWM_BITS + 1;

    typedef enum logic [1:0] {
        MODE_RAINBOW = 2'd0,
        MODE_HOLD    = 2'd1,
        MODE_STATIC  = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    mode_e                w_mode;
    logic                 w_step;
    logic [PRE_W-1:0]     r_pre;
    logic [2:0]           r_seg;
    logic [PWM_BITS-1:0]  r_pos;
    logic                 r_hue_wrap;
    logic [PWM_BITS-1:0]  r_pc;
    logic [PWM_BITS-1:0]  r_duty_r, r_duty_g, r_duty_b;
    logic [2:0]           r_led;
    logic [PWM_BITS-1:0]  w_wheel_r, w_wheel_g, w_wheel_b;
    logic [PWM_BITS-1:0]  w_src_r, w_src_g, w_src_b;
    logic [PWM_BITS-1:0]  w_scl_r, w_scl_g, w_scl_b;
    logic [2:0]           w_lit;

    assign w_mode = mode_e'(mode);
    assign w_step = (w_mode == MODE_RAINBOW) && (r_pre == PRE_LAST);

    // Product is formed at full width so brightness = MAX returns src exactly.
    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] s,
                                                  input logic [PWM_BITS-1:0] b);
        logic [PROD_W-1:0] p;
        p = PROD_W'(s) * (PROD_W'(b) + PROD_W'(1));
        return PWM_BITS'(p >> PWM_BITS);
    endfunction

    // Prescaler runs only while sweeping; any other mode parks it at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_mode != MODE_RAINBOW || w_step) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Hue position; seg 6/7 are recovered to 0 on the next step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= '0;
            r_pos      <= '0;
            r_hue_wrap <= 1'b0;
        end else begin
            r_hue_wrap <= w_step && (r_seg == 3'd5) && (r_pos == MAX);
            if (w_step) begin
                if (r_pos == MAX) begin
                    r_pos <= '0;
                    r_seg <= (r_seg >= 3'd5) ? 3'd0 : r_seg + 3'd1;
                end else begin
                    r_pos <= r_pos + PWM_BITS'(1);
                    if (r_seg > 3'd5) begin
                        r_seg <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_wheel_r = '0;
        w_wheel_g = '0;
        w_wheel_b = '0;
        case (r_seg)
            3'd0: begin w_wheel_r = MAX;         w_wheel_g = r_pos;       w_wheel_b = '0;          end
            3'd1: begin w_wheel_r = MAX - r_pos; w_wheel_g = MAX;         w_wheel_b = '0;          end
            3'd2: begin w_wheel_r = '0;          w_wheel_g = MAX;         w_wheel_b = r_pos;       end
            3'd3: begin w_wheel_r = '0;          w_wheel_g = MAX - r_pos; w_wheel_b = MAX;         end
            3'd4: begin w_wheel_r = r_pos;       w_wheel_g = '0;          w_wheel_b = MAX;         end
            3'd5: begin w_wheel_r = MAX;         w_wheel_g = '0;          w_wheel_b = MAX - r_pos; end
            default: begin
                w_wheel_r = '0;
                w_wheel_g = '0;
                w_wheel_b = '0;
            end
        endcase
    end

    always_comb begin
        if (w_mode == MODE_STATIC) begin
            w_src_r = color_in[3*PWM_BITS-1:2*PWM_BITS];
            w_src_g = color_in[2*PWM_BITS-1:PWM_BITS];
            w_src_b = color_in[PWM_BITS-1:0];
        end else begin
            w_src_r = w_wheel_r;
            w_src_g = w_wheel_g;
            w_src_b = w_wheel_b;
        end
        w_scl_r = scale(w_src_r, brightness);
        w_scl_g = scale(w_src_g, brightness);
        w_scl_b = scale(w_src_b, brightness);
    end

    // Duty only reloads at the last count so each period uses one value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_duty_r <= '0;
            r_duty_g <= '0;
            r_duty_b <= '0;
        end else begin
            r_pc <= r_pc + PWM_BITS'(1);
            if (r_pc == MAX) begin
                r_duty_r <= w_scl_r;
                r_duty_g <= w_scl_g;
                r_duty_b <= w_scl_b;
            end
        end
    end

    assign w_lit = {r_pc < r_duty_r, r_pc < r_duty_g, r_pc < r_duty_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= {3{ACTIVE_LOW}};
        end else if (w_mode == MODE_OFF) begin
            r_led <= {3{ACTIVE_LOW}};
        end else begin
            r_led <= w_lit ^ {3{ACTIVE_LOW}};
        end
    end

    assign led      = r_led;
    assign hue_wrap = r_hue_wrap;

endmodule

// File: tb/tb_rainbow_pwm.sv
// Self-checking bench for rainbow_pwm with PWM_BITS=4, STEP_DIV=4, ACTIVE_LOW=1.
module tb_rainbow_pwm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [11:0] color_in;
    logic [3:0]  brightness;
    logic [2:0]  led;
    logic        hue_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string name;
        int    r;
        int    g;
        int    b;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [11:0] color;
        logic [3:0]  bright;
        int          r;
        int          g;
        int          b;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    rainbow_pwm #(
        .PWM_BITS   (4),
        .STEP_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .color_in   (color_in),
        .brightness (brightness),
        .led        (led),
        .hue_wrap   (hue_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance at least one negedge, then until pc == v (bounded).
    task automatic wait_pc(input int v);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (int'(dut.r_pc) != v && k < 64);
        if (int'(dut.r_pc) != v) check("wait_pc_timeout", int'(dut.r_pc), v);
    endtask

    // Called at a negedge where pc == 0; counts lit (low) pin cycles over
    // the period, optionally changing color_in when pc reaches chg_pc.
    task automatic count_period(input int chg_pc, input logic [11:0] chg_color);
        int   lr, lg, lb;
        exp_t e;
        lr = 0; lg = 0; lb = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led[2] == 1'b0) lr++;
            if (led[1] == 1'b0) lg++;
            if (led[0] == 1'b0) lb++;
            if (chg_pc >= 0 && int'(dut.r_pc) == chg_pc) color_in = chg_color;
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got a period with no expected entry");
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_R"}, lr, e.r);
            check({e.name, "_G"}, lg, e.g);
            check({e.name, "_B"}, lb, e.b);
        end
    endtask

    task automatic measure(input string name, input int r, input int g, input int b);
        exp_t e;
        e.name = name; e.r = r; e.g = g; e.b = b;
        sb_q.push_back(e);
        wait_pc(0);
        count_period(-1, 12'h000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        int   cnt;
        exp_t e;

        vecs[0] = '{"static_scale7",  2'd2, 12'hF80, 4'd7,  7,  4,  0};
        vecs[1] = '{"static_full",    2'd2, 12'hFFF, 4'd15, 15, 15, 15};
        vecs[2] = '{"static_black",   2'd2, 12'h000, 4'd15, 0,  0,  0};
        vecs[3] = '{"static_mixed",   2'd2, 12'hA53, 4'd15, 10, 5,  3};
        vecs[4] = '{"static_bright0", 2'd2, 12'hF80, 4'd0,  0,  0,  0};
        vecs[5] = '{"static_scale11", 2'd2, 12'hC49, 4'd11, 9,  3,  6};
        vecs[6] = '{"off_mode",       2'd3, 12'hFFF, 4'd15, 0,  0,  0};

        // Reset behaviour.
        rst_n = 1'b0; mode = 2'd0; color_in = '0; brightness = 4'd15;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (led !== 3'b111 || hue_wrap !== 1'b0) bad++;
        end
        check("reset_outputs_held", bad, 0);
        check("reset_pc", int'(dut.r_pc), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (led !== 3'b111) bad++;
        end
        check("post_reset_dark_16", bad, 0);
        @(negedge clk);
        check("first_lit_R_cycle17", int'(led[2]), 0);

        // Rainbow sweep: wrap period and pulse width.
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!hue_wrap && cnt < 1000);
        check("first_wrap_seen", int'(hue_wrap), 1);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            check("wrap_pulse_width", int'(hue_wrap), 0);
            cnt = 1;
            do begin @(negedge clk); cnt++; end while (!hue_wrap && cnt < 1000);
            check("wrap_period", cnt, 384);
        end
        check("wrap_seg0", int'(dut.r_seg), 0);
        check("wrap_pos0", int'(dut.r_pos), 0);
        mode = 2'd1;
        measure("seg0_pos0", 15, 0, 0);

        // Hold at seg2/pos5.
        mode = 2'd0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end
        while (!(dut.r_seg == 3'd2 && dut.r_pos == 4'd5) && cnt < 400);
        check("reach_seg2_pos5", int'(dut.r_seg) * 16 + int'(dut.r_pos), 37);
        mode = 2'd1;
        bad = 0; cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dut.r_seg != 3'd2 || dut.r_pos != 4'd5) bad++;
            if (hue_wrap) cnt++;
        end
        check("hold_frozen", bad, 0);
        check("hold_no_wrap", cnt, 0);
        measure("hold_seg2_pos5", 0, 15, 5);
        mode = 2'd0;
        repeat (3) @(negedge clk);
        check("resume_pos_3cyc", int'(dut.r_pos), 5);
        @(negedge clk);
        check("resume_pos_4cyc", int'(dut.r_pos), 6);

        // Table-driven static/off vectors through the scoreboard.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            mode = vecs[v].mode; color_in = vecs[v].color; brightness = vecs[v].bright;
            measure(vecs[v].name, vecs[v].r, vecs[v].g, vecs[v].b);
        end

        // Glitch-free duty update mid-period.
        @(negedge clk);
        mode = 2'd2; brightness = 4'd15; color_in = 12'h200;
        wait_pc(0);
        wait_pc(0);
        e.name = "glitch_old"; e.r = 2;  e.g = 0; e.b = 0; sb_q.push_back(e);
        e.name = "glitch_new"; e.r = 12; e.g = 0; e.b = 0; sb_q.push_back(e);
        count_period(5, 12'hC00);
        count_period(-1, 12'h000);

        // Off mid-period.
        color_in = 12'hFFF;
        wait_pc(0);
        wait_pc(0);
        wait_pc(3);
        check("lit_before_off", int'(led), 0);
        mode = 2'd3;
        @(negedge clk);
        check("off_next_cycle", int'(led), 7);
        check("off_pc_continues", int'(dut.r_pc), 4);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (led !== 3'b111) bad++;
        end
        check("off_stays_dark", bad, 0);

        // Asynchronous reset mid-period.
        mode = 2'd2;
        wait_pc(0);
        wait_pc(7);
        check("lit_before_reset", int'(led), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led", int'(led), 7);
        check("async_reset_pc", int'(dut.r_pc), 0);
        check("async_reset_seg_pos", int'(dut.r_seg) * 16 + int'(dut.r_pos), 0);
        check("async_reset_pre", int'(dut.r_pre), 0);
        check("async_reset_duty_r", int'(dut.r_duty_r), 0);
        check("async_reset_wrap", int'(hue_wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
